// File: rtl/cim_output_accum.sv
// Receive-side shift-add accumulator for the bit-serial CIM array: weights per-column
// popcounts by bit-plane and returns one signed dot product per column over valid/ready.
//
// state | meaning
// IDLE  | no run in progress, waiting for start
// ACCUM | taking bit-planes, LSB first, into the column accumulators
// HOLD  | result presented on out_acc until downstream accepts it
module cim_output_accum #(
    parameter int N_COL  = 8,
    parameter int PSUM_W = 6,
    parameter int ACC_W  = 16
) (
    input  logic                      clk,
    input  logic                      RSTN,
    input  logic                      start,
    input  logic                      in_fp,
    input  logic                      psum_valid,
    input  logic [N_COL*PSUM_W-1:0]   psum,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_COL*ACC_W-1:0]    out_acc,
    output logic                      out_fp,
    output logic                      busy,
    output logic                      err_overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_bit_cnt;
    logic               r_mode;
    logic               r_err;
    logic [ACC_W-1:0]   r_acc  [N_COL];
    logic [ACC_W-1:0]   w_term [N_COL];
    logic               w_last;
    logic               w_take;
    logic               w_clear;

    assign w_last  = r_mode ? (r_bit_cnt == 3'd2) : (r_bit_cnt == 3'd7);
    // A start in ACCUM wins over a same-cycle plane: the plane belongs to the aborted run.
    assign w_take  = (r_state == ACCUM) && psum_valid && !start;
    assign w_clear = start && ((r_state == IDLE) || (r_state == ACCUM) ||
                               ((r_state == HOLD) && out_ready));

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = ACCUM;
            end
            ACCUM: begin
                if (w_take && w_last) w_state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) w_state_nxt = start ? ACCUM : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != IDLE);
        out_valid = (r_state == HOLD);
    end

    // Int plane 7 is the sign plane and carries weight -128; every other plane is +2^k.
    always_comb begin
        for (int c = 0; c < N_COL; c++) begin
            w_term[c] = {{(ACC_W-PSUM_W){1'b0}}, psum[c*PSUM_W +: PSUM_W]} << r_bit_cnt;
            if (!r_mode && (r_bit_cnt == 3'd7)) begin
                w_term[c] = -w_term[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            r_bit_cnt <= 3'd0;
            r_mode    <= 1'b0;
            r_err     <= 1'b0;
            for (int c = 0; c < N_COL; c++) r_acc[c] <= '0;
        end else begin
            if (w_clear) begin
                r_bit_cnt <= 3'd0;
                r_mode    <= in_fp;
                for (int c = 0; c < N_COL; c++) r_acc[c] <= '0;
            end else if (w_take) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                for (int c = 0; c < N_COL; c++) r_acc[c] <= r_acc[c] + w_term[c];
            end
            if ((r_state == HOLD) && start && !out_ready) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < N_COL; c++) begin
            out_acc[c*ACC_W +: ACC_W] = r_acc[c];
        end
    end

    assign out_fp      = r_mode;
    assign err_overrun = r_err;

endmodule

// File: tb/tb_cim_output_accum.sv
// Directed bench for cim_output_accum: hand-computed results for int8 and fp runs,
// gaps, backpressure, restart, simultaneous handshake/start and mid-run reset.
module tb_cim_output_accum;

    localparam int N_COL  = 8;
    localparam int PSUM_W = 6;
    localparam int ACC_W  = 16;

    logic                      clk = 1'b0;
    logic                      RSTN;
    logic                      start;
    logic                      in_fp;
    logic                      psum_valid;
    logic [N_COL*PSUM_W-1:0]   psum;
    logic                      out_valid;
    logic                      out_ready;
    logic [N_COL*ACC_W-1:0]    out_acc;
    logic                      out_fp;
    logic                      busy;
    logic                      err_overrun;

    int checks = 0;
    int errors = 0;
    logic [ACC_W-1:0] held;

    cim_output_accum #(.N_COL(N_COL), .PSUM_W(PSUM_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .RSTN(RSTN), .start(start), .in_fp(in_fp),
        .psum_valid(psum_valid), .psum(psum), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_fp(out_fp),
        .busy(busy), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] acc_of(input int c);
        return out_acc[c*ACC_W +: ACC_W];
    endfunction

    task automatic plane(input int c, input logic [PSUM_W-1:0] v);
        psum = '0;
        psum[c*PSUM_W +: PSUM_W] = v;
        psum_valid = 1'b1;
        tick();
        psum_valid = 1'b0;
        psum = '0;
    endtask

    task automatic begin_run(input logic fp);
        start = 1'b1;
        in_fp = fp;
        tick();
        start = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        RSTN = 1'b0; start = 1'b0; in_fp = 1'b0; psum_valid = 1'b0;
        psum = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err_overrun}, 32'd0);
        chk("rst_fp", {31'd0, out_fp}, 32'd0);
        chk("rst_acc0", {16'd0, acc_of(0)}, 32'd0);
        RSTN = 1'b1;
        tick();

        // 1: int, col0 = 1 on every plane -> -1
        begin_run(1'b0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 7; k++) plane(0, 6'd1);
        chk("t1_not_yet", {31'd0, out_valid}, 32'd0);
        plane(0, 6'd1);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_acc0", {16'd0, acc_of(0)}, 32'h0000_FFFF);
        chk("t1_acc1", {16'd0, acc_of(1)}, 32'd0);
        chk("t1_fp", {31'd0, out_fp}, 32'd0);
        accept();
        chk("t1_done_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_done_busy", {31'd0, busy}, 32'd0);

        // 2: fp, all columns 36 on 3 planes -> 252 each
        begin_run(1'b1);
        psum = {N_COL{6'd36}};
        psum_valid = 1'b1;
        tick(); tick();
        chk("t2_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        psum_valid = 1'b0;
        chk("t2_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_fp", {31'd0, out_fp}, 32'd1);
        for (int c = 0; c < N_COL; c++) chk($sformatf("t2_acc%0d", c), {16'd0, acc_of(c)}, 32'd252);
        accept();

        // 3: int, col0 = 36 on the sign plane only, with gaps -> -4608
        begin_run(1'b0);
        for (int k = 0; k < 8; k++) begin
            plane(0, (k == 7) ? 6'd36 : 6'd0);
            if (k < 7) begin
                tick(); tick();
                chk($sformatf("t3_gap_valid%0d", k), {31'd0, out_valid}, 32'd0);
            end
        end
        chk("t3_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_acc0", {16'd0, acc_of(0)}, 32'h0000_EE00);
        accept();
        begin_run(1'b0);
        for (int k = 0; k < 8; k++) plane(0, (k == 7) ? 6'd36 : 6'd0);
        chk("t3_nogap_acc0", {16'd0, acc_of(0)}, 32'h0000_EE00);

        // 4: backpressure with a dropped start
        held = acc_of(0);
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            in_fp = 1'b1;
            tick();
            start = 1'b0;
            chk($sformatf("t4_valid%0d", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("t4_acc%0d", k), {16'd0, acc_of(0)}, {16'd0, held});
        end
        chk("t4_err", {31'd0, err_overrun}, 32'd1);
        chk("t4_fp_held", {31'd0, out_fp}, 32'd0);
        accept();
        chk("t4_idle_busy", {31'd0, busy}, 32'd0);
        chk("t4_idle_valid", {31'd0, out_valid}, 32'd0);

        // 5: restart mid-run, then simultaneous handshake and start
        RSTN = 1'b0; tick(); RSTN = 1'b1;
        chk("t5_err_cleared", {31'd0, err_overrun}, 32'd0);
        begin_run(1'b0);
        for (int k = 0; k < 3; k++) plane(0, 6'd5);
        start = 1'b1; in_fp = 1'b0;
        psum = '0; psum[0 +: PSUM_W] = 6'd33; psum_valid = 1'b1;
        tick();
        start = 1'b0; psum_valid = 1'b0;
        chk("t5_restart_acc0", {16'd0, acc_of(0)}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (k == 1)      plane(0, 6'd2);
            else if (k == 7) plane(1, 6'd1);
            else             plane(2, 6'd0);
        end
        chk("t5_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_acc0", {16'd0, acc_of(0)}, 32'd4);
        chk("t5_acc1", {16'd0, acc_of(1)}, 32'h0000_FF80);
        out_ready = 1'b1; start = 1'b1; in_fp = 1'b1;
        tick();
        out_ready = 1'b0; start = 1'b0;
        chk("t5_sim_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_sim_busy", {31'd0, busy}, 32'd1);
        chk("t5_sim_acc1", {16'd0, acc_of(1)}, 32'd0);
        for (int k = 0; k < 3; k++) plane(2, 6'd1);
        chk("t5_fp_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_fp_acc2", {16'd0, acc_of(2)}, 32'd7);
        chk("t5_fp_mode", {31'd0, out_fp}, 32'd1);
        chk("t5_err", {31'd0, err_overrun}, 32'd0);
        accept();

        // 6: reset during plane 4, then planes without start are ignored
        begin_run(1'b1);
        begin_run(1'b0);
        for (int k = 0; k < 4; k++) plane(0, 6'd1);
        RSTN = 1'b0; psum = '0; psum[0 +: PSUM_W] = 6'd1; psum_valid = 1'b1;
        tick();
        RSTN = 1'b1;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_acc0", {16'd0, acc_of(0)}, 32'd0);
        chk("t6_fp", {31'd0, out_fp}, 32'd0);
        chk("t6_err", {31'd0, err_overrun}, 32'd0);
        for (int k = 0; k < 8; k++) tick();
        psum_valid = 1'b0;
        chk("t6_ign_busy", {31'd0, busy}, 32'd0);
        chk("t6_ign_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_ign_acc0", {16'd0, acc_of(0)}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
